sel_sequencer: RTL and testbench
================================

Name: sel_sequencer

Overview:
- Controller and configuration source for the magnitude/phase processor of the self-excited loop.
- Generates the 8-cycle frame sync.
- Holds a host-writable, double-buffered bank for the channel-multiplexed controls (setpoint, coefficients, limits) and serves them with dpram-style 1-cycle read latency.
- Runs the operating-mode state machine: amplitude ramp, SEL lock detection, clip fault, driven from the processor's cmp_event flags.

Parameters:
lock_frames, 64, consecutive clean frames (no mag/phase error event) required to declare lock
clip_frames, 16, consecutive clipped frames required to declare fault
cw, 7, width of the lock and clip frame counters; must hold max(lock_frames, clip_frames)

Ports:
clk  in  1  system clock
rst  in  1  reset
host_we  in  1  shadow-bank write strobe
host_addr  in  4  shadow register address
host_data  in  18  shadow write data
host_apply  in  1  request shadow-to-active commit at next sync
enable  in  1  level; run the loop
fault_clear  in  1  pulse; leave FAULT
cmp_event  in  12  event flags from the processor: [1:0] coarse mag/phase error, [11:8] clip
setmp_addr  in  2  setpoint read address
coeff_addr  in  2  coefficient read address
lim_addr  in  2  limit read address
setmp  out  18  signed setpoint read data
coeff  out  18  signed coefficient read data
lim  out  18  signed limit read data
sync  out  1  frame strobe, one cycle in eight
sel_en  out  1  SEL enable
mode  out  3  FSM state encoding
locked  out  1  high in LOCKED
fault  out  1  high in FAULT

Behaviour:
- Reset is asynchronous and active-high on rst. All registers clear on rst: both banks 0, outputs 0, mode IDLE.
- Frame:
  - 3-bit counter resets to 0 and increments every clk.
  - sync is registered, asserted the cycle after the counter equals 7.
  - First sync follows the 8th rising edge after rst deasserts; sync then repeats every 8 cycles.
- Host address map (shadow bank):
  - 0: magnitude target; 1: phase setpoint.
  - 2-5: coeff 0..3; 6-9: lim 0..3.
  - 10: ramp_step, unsigned; only bits [16:0] are used.
  - 11-15: writes ignored.
- Commit:
  - host_apply sets a pending flag. On a sync cycle with pending or host_apply high, the whole shadow bank copies to the active bank and pending clears.
  - A write in the commit cycle updates shadow only; active receives the pre-write value.
- Reads: each output is registered, valid 1 cycle after its address.
  - setmp_addr 0 → mag_cur; 1 → active phase; 2, 3 → 0.
  - coeff_addr n → coeff n; lim_addr n → lim n.
- Frame event accumulation:
  - err_f = OR of cmp_event[1:0] over every cycle since the previous sync, including the current sync cycle.
  - clip_f = OR of cmp_event[11:8] over the same window.
  - Both are evaluated on the sync cycle and then cleared.
- Ramp arithmetic, evaluated on sync in RAMP:
  - d = target − mag_cur, computed 19-bit signed.
  - If |d| ≤ step: mag_cur = target. Otherwise mag_cur ± step, toward target.
  - step = 0 holds mag_cur.
- FSM: all transitions on sync cycles except enable, fault_clear and rst, which act every cycle.
  - IDLE (0): mag_cur = 0, sel_en = 0. enable → RAMP.
  - RAMP (1): ramp each sync. mag_cur == target → LOCKING, counters cleared.
  - LOCKING (2): sel_en = 1. Per sync: lock counter increments if !err_f, else clears. Reaching lock_frames → LOCKED.
  - LOCKED (3): sel_en = 1, locked = 1.
    - err_f → LOCKING, lock counter 0.
    - A commit that changes the magnitude target → RAMP.
  - FAULT (4): mag_cur = 0, sel_en = 0, fault = 1. enable is ignored. fault_clear → IDLE.
- Clip monitor (RAMP, LOCKING, LOCKED):
  - Clip counter increments on clip_f, clears on !clip_f.
  - Reaching clip_frames → FAULT.
- Precedence: rst > clip fault > enable low (→ IDLE from any state except FAULT) > other transitions.
- fault_clear with enable still high: IDLE for 1 cycle, then RAMP.
- Counters saturate at their threshold; they never wrap.

Test Plan:
- Release rst: first sync after 8 edges, then every 8. All reads return 0. mode = 0.
- Write addr 2 = 1000 without apply → coeff_addr 0 reads 0. Pulse apply → from the next sync, reads 1000 one cycle after address. Write in the commit cycle → active keeps the old value.
- Target 10000, step 3000, enable → mag_cur 3000, 6000, 9000, 10000 on successive syncs, then mode = 2, sel_en = 1.
- In LOCKING, hold cmp_event = 0 for 64 frames → locked on the 64th sync. A single cmp_event[1] pulse mid-frame → mode = 2 at the next sync.
- cmp_event[9] high in 16 consecutive frames → fault = 1, sel_en = 0, setmp_addr 0 reads 0. 15 frames then one clean frame → no fault.
- Assert rst mid-RAMP (asynchronously, between edges) → outputs 0 immediately. fault_clear with enable = 1 → IDLE for 1 cycle, then RAMP.

Source files
------------

// File: rtl/sel_sequencer.sv
// sel_sequencer: frame-sync generator, double-buffered host control bank with
// registered read ports, and the operating-mode FSM (ramp, lock, clip fault)
// of the self-excited loop.
module sel_sequencer #(
   parameter int lock_frames = 64,
   parameter int clip_frames = 16,
   parameter int cw          = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        host_we,
   input  logic [3:0]  host_addr,
   input  logic [17:0] host_data,
   input  logic        host_apply,
   input  logic        enable,
   input  logic        fault_clear,
   input  logic [11:0] cmp_event,
   input  logic [1:0]  setmp_addr,
   input  logic [1:0]  coeff_addr,
   input  logic [1:0]  lim_addr,
   output logic [17:0] setmp,
   output logic [17:0] coeff,
   output logic [17:0] lim,
   output logic        sync,
   output logic        sel_en,
   output logic [2:0]  mode,
   output logic        locked,
   output logic        fault
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RAMP    = 3'd1,
      LOCKING = 3'd2,
      LOCKED  = 3'd3,
      FAULT   = 3'd4
   } state_t;

   localparam int             n_regs   = 11;
   localparam logic [cw-1:0]  lock_max = cw'(lock_frames);
   localparam logic [cw-1:0]  clip_max = cw'(clip_frames);

   state_t        state;
   state_t        next_state;
   logic [2:0]    frame_cnt;
   logic [17:0]   shadow [n_regs];
   logic [17:0]   active [n_regs];
   logic          pending;
   logic          commit;
   logic          target_change;
   logic          err_acc;
   logic          clip_acc;
   logic          err_f;
   logic          clip_f;
   logic [17:0]   mag_cur;
   logic [17:0]   target;
   logic [16:0]   step;
   logic [18:0]   diff;
   logic [18:0]   diff_abs;
   logic [17:0]   ramp_next;
   logic [cw-1:0] lock_cnt;
   logic [cw-1:0] clip_cnt;
   logic [cw-1:0] lock_inc;
   logic [cw-1:0] clip_inc;
   logic          clip_mon;
   logic          lock_hit;
   logic          clip_hit;
   logic          unused_bits;

   assign target        = active[0];
   assign step          = active[10][16:0];
   assign commit        = sync & (pending | host_apply);
   assign target_change = commit & (shadow[0] != active[0]);
   assign err_f         = err_acc | (|cmp_event[1:0]);
   assign clip_f        = clip_acc | (|cmp_event[11:8]);
   assign clip_mon      = (state == RAMP) || (state == LOCKING) || (state == LOCKED);
   assign lock_inc      = (lock_cnt >= lock_max) ? lock_cnt : lock_cnt + cw'(1);
   assign clip_inc      = (clip_cnt >= clip_max) ? clip_cnt : clip_cnt + cw'(1);
   assign lock_hit      = sync && (state == LOCKING) && !err_f && (lock_inc >= lock_max);
   assign clip_hit      = sync && clip_mon && clip_f && (clip_inc >= clip_max);
   assign unused_bits   = ^{cmp_event[7:2], active[10][17]};

   // Free-running 3-bit frame counter; sync is registered off count 7.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
         sync      <= 1'b0;
      end else begin
         frame_cnt <= frame_cnt + 3'd1;
         sync      <= (frame_cnt == 3'd7);
      end
   end

   // Shadow writes, pending-apply flag and shadow-to-active commit on sync.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the banks are a handful of flops, not RAM, so they are cleared like any other register.
         for (int i = 0; i < n_regs; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         pending <= 1'b0;
      end else begin
         if (host_we && (host_addr <= 4'd10))
            shadow[host_addr] <= host_data;
         // NOTE: non-blocking assignment means a same-cycle write is not seen here; active takes the pre-write shadow.
         if (commit) begin
            for (int i = 0; i < n_regs; i++)
               active[i] <= shadow[i];
            pending <= 1'b0;
         end else if (host_apply) begin
            pending <= 1'b1;
         end
      end
   end

   // Registered read ports, one cycle from address to data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         setmp <= '0;
         coeff <= '0;
         lim   <= '0;
      end else begin
         case (setmp_addr)
            2'd0:    setmp <= mag_cur;
            2'd1:    setmp <= active[1];
            default: setmp <= '0;
         endcase
         coeff <= active[4'd2 + {2'b00, coeff_addr}];
         lim   <= active[4'd6 + {2'b00, lim_addr}];
      end
   end

   // Error and clip flags ORed across the frame, cleared after each sync.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_acc  <= 1'b0;
         clip_acc <= 1'b0;
      end else if (sync) begin
         err_acc  <= 1'b0;
         clip_acc <= 1'b0;
      end else begin
         err_acc  <= err_f;
         clip_acc <= clip_f;
      end
   end

   // One ramp step of mag_cur toward the active target, snapping when within step.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      ramp_next = mag_cur;
      diff      = {target[17], target} - {mag_cur[17], mag_cur};
      diff_abs  = diff[18] ? (19'd0 - diff) : diff;
      if (diff_abs <= {2'b00, step})
         ramp_next = target;
      else if (diff[18])
         ramp_next = mag_cur - {1'b0, step};
      else
         ramp_next = mag_cur + {1'b0, step};
   end

   // Current magnitude: zero outside the active states, stepped on sync in RAMP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mag_cur <= '0;
      else if ((next_state == IDLE) || (next_state == FAULT))
         mag_cur <= '0;
      else if ((state == RAMP) && sync)
         mag_cur <= ramp_next;
   end

   // Consecutive clean-frame counter, live only while in LOCKING.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lock_cnt <= '0;
      else if ((state == LOCKING) && (next_state == LOCKING)) begin
         if (sync)
            lock_cnt <= err_f ? '0 : lock_inc;
      end else
         lock_cnt <= '0;
   end

   // Consecutive clipped-frame counter, live in RAMP, LOCKING and LOCKED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         clip_cnt <= '0;
      else if (clip_mon && (next_state != IDLE) && (next_state != FAULT) &&
               !((state == RAMP) && (next_state == LOCKING))) begin
         if (sync)
            clip_cnt <= clip_f ? clip_inc : '0;
      end else
         clip_cnt <= '0;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // FSM next state: clip fault beats enable-low, which beats the rest.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (enable) next_state = RAMP;
         RAMP:    if (sync && (ramp_next == target)) next_state = LOCKING;
         LOCKING: if (lock_hit) next_state = LOCKED;
         LOCKED: begin
            if (target_change)
               next_state = RAMP;
            else if (sync && err_f)
               next_state = LOCKING;
         end
         FAULT:   if (fault_clear) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if ((state != FAULT) && !enable)
         next_state = IDLE;
      if (clip_hit)
         next_state = FAULT;
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      mode   = state;
      sel_en = (state == LOCKING) || (state == LOCKED);
      locked = (state == LOCKED);
      fault  = (state == FAULT);
   end

endmodule

// File: tb/tb_sel_sequencer.sv
// Self-checking bench for sel_sequencer: table-driven bank vectors, hand-written
// commit/lock/clip/reset sequences, and randomized bank and ramp stimulus checked
// against an array/integer reference model.
module tb_sel_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        host_we = 1'b0;
   logic [3:0]  host_addr = '0;
   logic [17:0] host_data = '0;
   logic        host_apply = 1'b0;
   logic        enable = 1'b0;
   logic        fault_clear = 1'b0;
   logic [11:0] cmp_event = '0;
   logic [1:0]  setmp_addr = '0;
   logic [1:0]  coeff_addr = '0;
   logic [1:0]  lim_addr = '0;
   logic [17:0] setmp;
   logic [17:0] coeff;
   logic [17:0] lim;
   logic        sync;
   logic        sel_en;
   logic [2:0]  mode;
   logic        locked;
   logic        fault;

   always #5 clk = ~clk;

   sel_sequencer dut (
      .clk(clk), .rst(rst), .host_we(host_we), .host_addr(host_addr),
      .host_data(host_data), .host_apply(host_apply), .enable(enable),
      .fault_clear(fault_clear), .cmp_event(cmp_event), .setmp_addr(setmp_addr),
      .coeff_addr(coeff_addr), .lim_addr(lim_addr), .setmp(setmp), .coeff(coeff),
      .lim(lim), .sync(sync), .sel_en(sel_en), .mode(mode), .locked(locked),
      .fault(fault)
   );

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   logic [17:0] sh_m [11];
   logic [17:0] ac_m [11];
   bit          pend_m = 1'b0;
   int          exp_setmp_idle;
   int          exp_coeff;
   int          exp_lim;

   typedef struct {
      logic [3:0]  wa;
      logic [17:0] wd;
      bit          ap;
      logic [1:0]  sa;
      logic [1:0]  ca;
      logic [1:0]  la;
      int          es;
      int          ec;
      int          el;
   } vec_t;

   vec_t vt [6];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int s18(input logic [17:0] v);
      return int'($signed(v));
   endfunction

   function automatic bit is_sync();
      return (cyc > 0) && (cyc % 8 == 0);
   endfunction

   function automatic int ramp_model(input int m, input int t, input int s);
      int d;
      d = t - m;
      if (d >= -s && d <= s) return t;
      return (d > 0) ? m + s : m - s;
   endfunction

   task automatic model_clear();
      foreach (sh_m[i]) begin
         sh_m[i] = '0;
         ac_m[i] = '0;
      end
      pend_m = 1'b0;
      cyc    = 0;
   endtask

   // Advance one clock; the bank model applies what this edge should do.
   task automatic tick();
      bit sc;
      sc = is_sync();
      exp_setmp_idle = (setmp_addr == 2'd1) ? s18(ac_m[1]) : 0;
      exp_coeff      = s18(ac_m[2 + int'(coeff_addr)]);
      exp_lim        = s18(ac_m[6 + int'(lim_addr)]);
      if (sc && (pend_m || host_apply)) begin
         ac_m   = sh_m;
         pend_m = 1'b0;
      end else if (host_apply) begin
         pend_m = 1'b1;
      end
      if (host_we && host_addr <= 4'd10) sh_m[host_addr] = host_data;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic to_sync_edge();
      while (!is_sync()) tick();
      tick();
   endtask

   task automatic write_reg(input int a, input int d);
      host_we = 1'b1; host_addr = 4'(a); host_data = 18'(d);
      tick();
      host_we = 1'b0;
   endtask

   task automatic apply_pulse();
      host_apply = 1'b1;
      tick();
      host_apply = 1'b0;
   endtask

   task automatic mid_frame_pulse(input logic [11:0] ev);
      tick(); tick();
      cmp_event = ev;
      tick();
      cmp_event = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ramp_exp [4];
      int t, s, m;

      vt[0] = '{4'd2,  18'd1000,   1'b0, 2'd0, 2'd0, 2'd0, 0,    0,    0};
      vt[1] = '{4'd6,  18'(-5),    1'b1, 2'd1, 2'd0, 2'd0, 0,    1000, -5};
      vt[2] = '{4'd1,  18'd1234,   1'b1, 2'd1, 2'd0, 2'd0, 1234, 1000, -5};
      vt[3] = '{4'd5,  18'd7,      1'b1, 2'd2, 2'd3, 2'd3, 0,    7,    0};
      vt[4] = '{4'd12, 18'd999,    1'b1, 2'd3, 2'd1, 2'd1, 0,    0,    0};
      vt[5] = '{4'd9,  18'(-1),    1'b1, 2'd0, 2'd3, 2'd3, 0,    7,    -1};
      model_clear();

      // Reset state
      #12;
      check("rst_mode", mode, 0);
      check("rst_sync", sync, 0);
      check("rst_setmp", s18(setmp), 0);
      check("rst_coeff", s18(coeff), 0);
      check("rst_lim", s18(lim), 0);
      @(posedge clk);
      #3 rst = 1'b0;

      // First sync after the 8th edge, then every 8
      for (int i = 1; i <= 24; i++) begin
         tick();
         check($sformatf("sync_edge%0d", i), sync, (i % 8 == 0) ? 1 : 0);
      end
      check("idle_mode", mode, 0);

      // Table-driven bank vectors
      foreach (vt[k]) begin
         host_we = 1'b1; host_addr = vt[k].wa; host_data = vt[k].wd; host_apply = vt[k].ap;
         tick();
         host_we = 1'b0; host_apply = 1'b0;
         to_sync_edge();
         setmp_addr = vt[k].sa; coeff_addr = vt[k].ca; lim_addr = vt[k].la;
         tick();
         check($sformatf("vec%0d_setmp", k), s18(setmp), vt[k].es);
         check($sformatf("vec%0d_coeff", k), s18(coeff), vt[k].ec);
         check($sformatf("vec%0d_lim", k), s18(lim), vt[k].el);
      end

      // Write landing in the commit cycle stays in shadow only
      coeff_addr = 2'd1;
      host_we = 1'b1; host_addr = 4'd3; host_data = 18'd2000; host_apply = 1'b1;
      tick();
      host_we = 1'b0; host_apply = 1'b0;
      while (!is_sync()) tick();
      check("pre_commit_coeff1", s18(coeff), 0);
      host_we = 1'b1; host_addr = 4'd3; host_data = 18'd3000;
      tick();
      host_we = 1'b0;
      tick();
      check("commit_cycle_write_old", s18(coeff), 2000);
      apply_pulse();
      to_sync_edge();
      tick();
      check("commit_cycle_write_new", s18(coeff), 3000);

      // Randomized bank traffic against the model (loop disabled)
      for (int i = 0; i < 200; i++) begin
         host_we    = 1'($urandom_range(0, 1));
         host_addr  = 4'($urandom_range(0, 15));
         host_data  = 18'($urandom);
         host_apply = ($urandom_range(0, 9) == 0);
         setmp_addr = 2'($urandom_range(0, 3));
         coeff_addr = 2'($urandom_range(0, 3));
         lim_addr   = 2'($urandom_range(0, 3));
         tick();
         check("rand_setmp", s18(setmp), exp_setmp_idle);
         check("rand_coeff", s18(coeff), exp_coeff);
         check("rand_lim", s18(lim), exp_lim);
         check("rand_sync", sync, is_sync() ? 1 : 0);
      end
      host_we = 1'b0; host_apply = 1'b0;

      // Ramp 0 -> 10000 with step 3000
      to_sync_edge();
      write_reg(0, 10000);
      write_reg(10, 3000);
      apply_pulse();
      to_sync_edge();
      setmp_addr = 2'd0;
      enable = 1'b1;
      tick();
      check("enable_to_ramp", mode, 1);
      ramp_exp = '{3000, 6000, 9000, 10000};
      for (int k = 0; k < 4; k++) begin
         to_sync_edge();
         check($sformatf("ramp%0d_mode", k), mode, (k == 3) ? 2 : 1);
         tick();
         check($sformatf("ramp%0d_mag", k), s18(setmp), ramp_exp[k]);
      end
      check("locking_sel_en", sel_en, 1);

      // 64 clean frames to lock
      for (int f = 1; f <= 64; f++) begin
         to_sync_edge();
         check($sformatf("lock_frame%0d", f), mode, (f == 64) ? 3 : 2);
      end
      check("locked_flag", locked, 1);

      // Mid-frame error in LOCKED drops to LOCKING at the next sync
      mid_frame_pulse(12'h002);
      check("err_before_sync", mode, 3);
      to_sync_edge();
      check("err_to_locking", mode, 2);
      check("err_unlocked", locked, 0);
      check("err_sel_en", sel_en, 1);

      // Error in LOCKING restarts the clean-frame count
      for (int f = 1; f <= 40; f++) begin
         to_sync_edge();
         check("pre_err_locking", mode, 2);
      end
      mid_frame_pulse(12'h001);
      to_sync_edge();
      check("err_frame_locking", mode, 2);
      for (int f = 1; f <= 64; f++) begin
         to_sync_edge();
         check($sformatf("relock_frame%0d", f), mode, (f == 64) ? 3 : 2);
      end

      // Error asserted only in the sync cycle still counts
      while (!is_sync()) tick();
      cmp_event = 12'h001;
      tick();
      cmp_event = '0;
      check("sync_cycle_err", mode, 2);

      // 15 clipped frames then a clean one: no fault
      cmp_event = 12'h200;
      for (int f = 1; f <= 15; f++) begin
         to_sync_edge();
         check("clip15_no_fault", fault, 0);
      end
      cmp_event = '0;
      to_sync_edge();
      check("clip_clean_frame", fault, 0);

      // 16 consecutive clipped frames: fault
      cmp_event = 12'h200;
      for (int f = 1; f <= 16; f++) begin
         to_sync_edge();
         check($sformatf("clip_frame%0d", f), mode, (f == 16) ? 4 : 2);
      end
      cmp_event = '0;
      check("fault_flag", fault, 1);
      check("fault_sel_en", sel_en, 0);
      check("fault_locked", locked, 0);
      tick(); tick();
      check("fault_mag_zero", s18(setmp), 0);
      for (int i = 0; i < 5; i++) tick();
      check("fault_ignores_enable", mode, 4);
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      check("fault_clear_idle", mode, 0);
      tick();
      check("fault_clear_ramp", mode, 1);

      // Asynchronous reset mid-RAMP
      to_sync_edge();
      check("rst_ramp_mode", mode, 1);
      tick();
      check("rst_ramp_mag", s18(setmp), 3000);
      #2 rst = 1'b1;
      #1;
      check("async_rst_mode", mode, 0);
      check("async_rst_setmp", s18(setmp), 0);
      check("async_rst_sel_en", sel_en, 0);
      check("async_rst_sync", sync, 0);
      enable = 1'b0;
      coeff_addr = 2'd1;
      model_clear();
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
      check("post_rst_coeff", s18(coeff), 0);
      check("post_rst_mode", mode, 0);

      // Randomized ramps against the integer model
      for (int r = 0; r < 4; r++) begin
         enable = 1'b0;
         to_sync_edge();
         s = int'($urandom_range(2000, 40000));
         if (r == 0) t = 3 * s;
         else if (r == 1) t = -int'($urandom_range(10000, 100000));
         else t = int'($urandom_range(0, 200000)) - 100000;
         write_reg(0, t);
         write_reg(10, s);
         apply_pulse();
         to_sync_edge();
         enable = 1'b1;
         tick();
         m = 0;
         for (int n = 0; n < 60 && m != t; n++) begin
            to_sync_edge();
            m = ramp_model(m, t, s);
            check($sformatf("rramp%0d_mode", r), mode, (m == t) ? 2 : 1);
            tick();
            check($sformatf("rramp%0d_mag", r), s18(setmp), m);
         end
         check($sformatf("rramp%0d_sel_en", r), sel_en, 1);
      end

      // Commit in LOCKED: same target stays, new target re-ramps
      for (int f = 1; f <= 64; f++) to_sync_edge();
      check("relock_final", mode, 3);
      write_reg(1, 555);
      apply_pulse();
      to_sync_edge();
      check("same_target_stays", mode, 3);
      write_reg(0, (t > 0) ? t - 1000 : t + 1000);
      apply_pulse();
      to_sync_edge();
      check("target_change_ramp", mode, 1);
      to_sync_edge();
      check("retarget_locking", mode, 2);
      tick();
      check("retarget_mag", s18(setmp), (t > 0) ? t - 1000 : t + 1000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
